booth_mul_sequencer: RTL and testbench

Multi-cycle signed multiplier controller for the CPU's MUL instruction path. It accepts two WIDTH-bit two's-complement operands on a start pulse and runs one radix-2 Booth recode/add/shift step per clock for WIDTH clocks. It then registers the 2·WIDTH-bit product into HI/LO output registers and pulses done. It replaces the single-cycle combinational multiplier on the critical path. The control unit holds the pipeline while busy_o is high.

---
 rtl/booth_mul_sequencer_if.sv | 13 +
 rtl/booth_mul_sequencer.sv | 54 +++++
 tb/tb_booth_mul_sequencer.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/booth_mul_sequencer_if.sv
// booth_mul_sequencer_if: start/operand request and product/status response bundle
interface booth_mul_sequencer_if #(parameter int WIDTH = 32);
  logic             start_i;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             ready_o;
  logic             busy_o;
  logic             done_o;
  logic [WIDTH-1:0] hi_o;
  logic [WIDTH-1:0] lo_o;
  modport master (output start_i, a_i, b_i, input ready_o, busy_o, done_o, hi_o, lo_o);
  modport slave (input start_i, a_i, b_i, output ready_o, busy_o, done_o, hi_o, lo_o);
endinterface

// File: rtl/booth_mul_sequencer.sv
// booth_mul_sequencer: radix-2 Booth signed multiplier, one recode/add/shift step per clock
module booth_mul_sequencer #(
  parameter int WIDTH = 32
) (
  input logic                  clk,
  input logic                  clr,
  booth_mul_sequencer_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t         state, state_nx;
  logic [WIDTH:0] m, a, sum;
  logic [WIDTH-1:0] q;
  logic           q_m1;
  logic [CW-1:0]  cnt;
  always_ff @(posedge clk or posedge clr)
    if (clr) state <= IDLE;
    else state <= state_nx;
  always_comb
    state_nx = state == IDLE ? (bus.start_i ? CALC : IDLE) :
               state == CALC ? (cnt == CW'(1) ? DONE : CALC) : IDLE;
  always_comb begin
    bus.ready_o = state == IDLE;
    bus.busy_o  = state != IDLE;
  end
  // A is one bit wider than the operand so A - M cannot overflow for the most negative multiplicand
  always_comb sum = q[0] == q_m1 ? a : q[0] ? a - m : a + m;
  always_ff @(posedge clk or posedge clr)
    if (clr) begin
      m          <= '0;
      a          <= '0;
      q          <= '0;
      q_m1       <= 1'b0;
      cnt        <= '0;
      bus.done_o <= 1'b0;
      bus.hi_o   <= '0;
      bus.lo_o   <= '0;
    end else begin
      bus.done_o <= state == DONE;
      if (state == IDLE && bus.start_i) begin
        m    <= {bus.a_i[WIDTH-1], bus.a_i};
        a    <= '0;
        q    <= bus.b_i;
        q_m1 <= 1'b0;
        cnt  <= CW'(WIDTH);
      end else if (state == CALC) begin
        {a, q, q_m1} <= {sum[WIDTH], sum, q};
        cnt          <= cnt - 1'b1;
      end else if (state == DONE) begin
        bus.hi_o <= a[WIDTH-1:0];
        bus.lo_o <= q;
      end
    end
endmodule

// File: tb/tb_booth_mul_sequencer.sv
// tb_booth_mul_sequencer: scoreboard bench for the Booth multiplier sequencer
module tb_booth_mul_sequencer;
  logic clk = 1'b0;
  logic clr = 1'b1;
  int tests = 0;
  int fails = 0;
  int done_cnt = 0;
  int acc_cnt = 0;
  logic [63:0] sb[$];
  logic [63:0] exp_p;
  logic [31:0] corners[5] = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF};
  booth_mul_sequencer_if #(.WIDTH(32)) bus();
  booth_mul_sequencer #(.WIDTH(32)) dut(.clk(clk), .clr(clr), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [63:0] prod(input logic [31:0] x, input logic [31:0] y);
    longint p;
    p = longint'($signed(x)) * longint'($signed(y));
    return p;
  endfunction
  always @(negedge clk)
    if (bus.done_o) begin
      done_cnt++;
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL sb_unexpected_done got hi=%h lo=%h, no product expected", bus.hi_o, bus.lo_o);
      end else begin
        exp_p = sb.pop_front();
        if ({bus.hi_o, bus.lo_o} !== exp_p) begin
          fails++;
          $display("FAIL sb_product got %h_%h expected %h", bus.hi_o, bus.lo_o, exp_p);
        end
      end
    end
  task automatic issue(input logic [31:0] x, input logic [31:0] y);
    logic acc;
    bus.start_i = 1'b1;
    bus.a_i = x;
    bus.b_i = y;
    acc = bus.ready_o;
    @(posedge clk);
    #1 bus.start_i = 1'b0;
    if (acc) begin
      sb.push_back(prod(x, y));
      acc_cnt++;
    end
  endtask
  task automatic wait_done(input int lim, output int n, output int busy_n);
    n = 0;
    busy_n = 0;
    do begin
      @(negedge clk);
      n++;
      if (bus.busy_o) busy_n++;
    end while (!bus.done_o && n < lim);
    tests++;
    if (!bus.done_o) begin
      fails++;
      $display("FAIL done_timeout no done_o within %0d cycles", lim);
    end
  endtask
  task automatic test_reset;
    clr = 1'b1;
    bus.start_i = 1'b0;
    bus.a_i = '0;
    bus.b_i = '0;
    repeat (2) @(negedge clk);
    tests += 5;
    if (bus.ready_o !== 1'b1) begin fails++; $display("FAIL reset_ready got %b expected 1", bus.ready_o); end
    if (bus.busy_o !== 1'b0) begin fails++; $display("FAIL reset_busy got %b expected 0", bus.busy_o); end
    if (bus.done_o !== 1'b0) begin fails++; $display("FAIL reset_done got %b expected 0", bus.done_o); end
    if (bus.hi_o !== 32'h0) begin fails++; $display("FAIL reset_hi got %h expected 0", bus.hi_o); end
    if (bus.lo_o !== 32'h0) begin fails++; $display("FAIL reset_lo got %h expected 0", bus.lo_o); end
    clr = 1'b0;
  endtask
  task automatic test_basic;
    int n, b;
    @(negedge clk);
    issue(32'd7, 32'd3);
    wait_done(100, n, b);
    tests += 5;
    if (n !== 34) begin fails++; $display("FAIL basic_latency got %0d expected 34", n); end
    if (b !== 33) begin fails++; $display("FAIL basic_busy_cycles got %0d expected 33", b); end
    if (bus.ready_o !== 1'b1) begin fails++; $display("FAIL basic_ready_in_done got %b expected 1", bus.ready_o); end
    if (bus.hi_o !== 32'h0) begin fails++; $display("FAIL basic_hi got %h expected 0", bus.hi_o); end
    if (bus.lo_o !== 32'h15) begin fails++; $display("FAIL basic_lo got %h expected 15", bus.lo_o); end
    @(negedge clk);
    tests++;
    if (bus.done_o !== 1'b0) begin fails++; $display("FAIL basic_done_pulse got %b expected 0", bus.done_o); end
  endtask
  task automatic test_back_to_back;
    int n, b;
    issue(32'hFFFFFFFB, 32'd3);
    wait_done(100, n, b);
    issue(32'd3, 32'hFFFFFFFB);
    wait_done(100, n, b);
    tests += 3;
    if (n !== 34) begin fails++; $display("FAIL b2b_spacing got %0d expected 34", n); end
    if (bus.hi_o !== 32'hFFFFFFFF) begin fails++; $display("FAIL b2b_hi got %h expected ffffffff", bus.hi_o); end
    if (bus.lo_o !== 32'hFFFFFFF1) begin fails++; $display("FAIL b2b_lo got %h expected fffffff1", bus.lo_o); end
  endtask
  task automatic test_extremes;
    int n, b;
    @(negedge clk);
    issue(32'h80000000, 32'h80000000);
    wait_done(100, n, b);
    tests += 2;
    if (bus.hi_o !== 32'h40000000) begin fails++; $display("FAIL min_sq_hi got %h expected 40000000", bus.hi_o); end
    if (bus.lo_o !== 32'h0) begin fails++; $display("FAIL min_sq_lo got %h expected 0", bus.lo_o); end
    issue(32'h80000000, 32'hFFFFFFFF);
    wait_done(100, n, b);
    tests += 2;
    if (bus.hi_o !== 32'h0) begin fails++; $display("FAIL min_neg1_hi got %h expected 0", bus.hi_o); end
    if (bus.lo_o !== 32'h80000000) begin fails++; $display("FAIL min_neg1_lo got %h expected 80000000", bus.lo_o); end
  endtask
  task automatic test_ignore_start;
    int n, d0;
    @(negedge clk);
    issue(32'd6, 32'd7);
    d0 = done_cnt;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      bus.start_i = bus.busy_o ? ~bus.start_i : 1'b0;
      bus.a_i = 32'd1;
      bus.b_i = 32'd1;
    end while (!bus.done_o && n < 100);
    bus.start_i = 1'b0;
    repeat (40) @(negedge clk);
    tests += 3;
    if (done_cnt - d0 !== 1) begin fails++; $display("FAIL ignore_done_count got %0d expected 1", done_cnt - d0); end
    if (bus.hi_o !== 32'h0) begin fails++; $display("FAIL ignore_hi got %h expected 0", bus.hi_o); end
    if (bus.lo_o !== 32'h2A) begin fails++; $display("FAIL ignore_lo got %h expected 2a", bus.lo_o); end
  endtask
  task automatic test_abort;
    int n, b, d0;
    @(negedge clk);
    issue(32'd9, 32'd9);
    repeat (9) @(negedge clk);
    clr = 1'b1;
    sb.delete();
    acc_cnt--;
    #1;
    tests += 4;
    if (bus.hi_o !== 32'h0) begin fails++; $display("FAIL abort_hi got %h expected 0", bus.hi_o); end
    if (bus.lo_o !== 32'h0) begin fails++; $display("FAIL abort_lo got %h expected 0", bus.lo_o); end
    if (bus.ready_o !== 1'b1) begin fails++; $display("FAIL abort_ready got %b expected 1", bus.ready_o); end
    if (bus.busy_o !== 1'b0) begin fails++; $display("FAIL abort_busy got %b expected 0", bus.busy_o); end
    @(negedge clk);
    clr = 1'b0;
    d0 = done_cnt;
    repeat (40) @(negedge clk);
    tests++;
    if (done_cnt !== d0) begin fails++; $display("FAIL abort_no_done got %0d extra done pulses expected 0", done_cnt - d0); end
    issue(32'd9, 32'd9);
    wait_done(100, n, b);
    tests++;
    if (bus.lo_o !== 32'h51) begin fails++; $display("FAIL abort_retry_lo got %h expected 51", bus.lo_o); end
  endtask
  task automatic test_random;
    int n, b;
    logic [31:0] x, y;
    @(negedge clk);
    for (int i = 0; i < 1000; i++) begin
      x = $urandom_range(0, 7) < 5 ? corners[$urandom_range(0, 4)] : $urandom();
      y = $urandom_range(0, 7) < 5 ? corners[$urandom_range(0, 4)] : $urandom();
      issue(x, y);
      wait_done(100, n, b);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    repeat (5) @(negedge clk);
    tests += 2;
    if (done_cnt !== acc_cnt) begin fails++; $display("FAIL rand_done_count got %0d expected %0d", done_cnt, acc_cnt); end
    if (sb.size() !== 0) begin fails++; $display("FAIL rand_sb_leftover got %0d expected 0", sb.size()); end
  endtask
  initial begin
    test_reset;
    test_basic;
    test_back_to_back;
    test_extremes;
    test_ignore_start;
    test_abort;
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
